// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants and state type for the SHA-256 message padder
package sha256_pkg;

  localparam int BLK_BYTES       = 64;
  localparam int BLK_BITS        = 512;
  localparam int LEN_FIELD_BYTES = 8;
  localparam int LEN_OFFSET      = 56;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ACCUM,
    FULL,
    PAD1,
    PAD2
  } pad_state_t;

endpackage

// File: rtl/sha256_blk_buf.sv
// rtl/sha256_blk_buf.sv - 64-byte block buffer with byte-offset beat writes
//
// Purpose: holds the message bytes of the block being assembled. A beat of up
// to IN_BYTES bytes is written starting at byte offset off_i; byte 0 of the
// buffer is data_o[511:504]. Bytes that would land past byte 63 are dropped.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the buffer)
//   clr_i      : synchronous clear (wins over a write)
//   we_i       : write enable for the current beat
//   off_i      : byte offset of the first beat byte (0..64)
//   cnt_i      : number of leading beat bytes to write (<= IN_BYTES)
//   data_i     : beat bytes, byte 0 in the top lane
//   data_o     : 512-bit buffer contents
module sha256_blk_buf
  import sha256_pkg::*;
#(
  parameter int IN_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           we_i,
  input  logic [6:0]                     off_i,
  input  logic [$clog2(IN_BYTES+1)-1:0]  cnt_i,
  input  logic [IN_BYTES*8-1:0]          data_i,
  output logic [BLK_BITS-1:0]            data_o
);

  localparam int SHL = BLK_BITS - IN_BYTES * 8;

  logic [BLK_BITS-1:0]   mem_q;
  logic [IN_BYTES*8-1:0] lane_m;
  logic [BLK_BITS-1:0]   wr_data;
  logic [BLK_BITS-1:0]   wr_mask;

  // Beat is aligned to byte 0 of the block, then shifted down to the fill
  // offset; anything shifted past byte 63 simply falls off the end.
  assign lane_m  = ~({(IN_BYTES*8){1'b1}} >> {cnt_i, 3'b000});
  assign wr_data = (BLK_BITS'(data_i) << SHL) >> {off_i, 3'b000};
  assign wr_mask = (BLK_BITS'(lane_m) << SHL) >> {off_i, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (clr_i) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q <= (mem_q & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  assign data_o = mem_q;

endmodule

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - streaming SHA-256 message padder producing 512-bit blocks
//
// Purpose: accepts a byte stream in IN_BYTES-wide beats and emits padded
// 512-bit blocks (0x80 terminator, zero fill, 64-bit big-endian bit length).
// Optional macro SHA256_PADDER_STATS_EN adds blk_idx / msg_cnt outputs.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   data_in        : beat bytes, byte 0 in data_in[IN_BYTES*8-1 -: 8]
//   byte_valid     : number of valid leading bytes in the beat
//   data_valid     : beat present
//   msg_last       : beat closes the message
//   data_ready     : padder can take a beat
//   blk_out        : padded block, byte 0 in blk_out[511:504]
//   blk_valid      : blk_out valid
//   blk_ready      : core takes the block
//   blk_first      : block is the first of its message
//   blk_last       : block is the last of its message
//   proto_err      : sticky protocol-violation flag
//   blk_idx        : (stats) block index within the message
//   msg_cnt        : (stats) count of completed messages
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int IN_BYTES = 4,
  parameter int LEN_W    = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [IN_BYTES*8-1:0]          data_in,
  input  logic [$clog2(IN_BYTES+1)-1:0]  byte_valid,
  input  logic                           data_valid,
  input  logic                           msg_last,
  output logic                           data_ready,
  output logic [BLK_BITS-1:0]            blk_out,
  output logic                           blk_valid,
  input  logic                           blk_ready,
  output logic                           blk_first,
  output logic                           blk_last,
  output logic                           proto_err
`ifdef SHA256_PADDER_STATS_EN
  ,
  output logic [15:0]                    blk_idx,
  output logic [31:0]                    msg_cnt
`endif
);

  localparam int BV_W = $clog2(IN_BYTES + 1);

  pad_state_t                 state_q, state_d;
  logic [6:0]                 fill_q, fill_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic                       pad_pend_q, pad_pend_d;
  logic                       first_q, first_d;
  logic                       err_q, err_d;
  logic                       rdy_q;
  logic [BV_W-1:0]            bv_eff;
  logic [7:0]                 new_fill;
  logic                       accept, xfer, buf_clr;
  logic [BLK_BITS-1:0]        buf_data;
  logic [LEN_FIELD_BYTES*8-1:0] len64;

  // rdy_q keeps data_ready low until the first clock after reset release.
  assign data_ready = (state_q == ACCUM) && rdy_q;
  assign accept     = data_valid && data_ready;
  assign xfer       = blk_valid && blk_ready;
  assign bv_eff     = (byte_valid > BV_W'(IN_BYTES)) ? BV_W'(IN_BYTES) : byte_valid;
  assign new_fill   = {1'b0, fill_q} + 8'(bv_eff);
  assign len64      = (LEN_FIELD_BYTES*8)'(len_q);
  assign proto_err  = err_q;

  sha256_blk_buf #(.IN_BYTES(IN_BYTES)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (buf_clr),
    .we_i   (accept),
    .off_i  (fill_q),
    .cnt_i  (bv_eff),
    .data_i (data_in),
    .data_o (buf_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      fill_q     <= '0;
      len_q      <= '0;
      pad_pend_q <= 1'b0;
      first_q    <= 1'b1;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      len_q      <= len_d;
      pad_pend_q <= pad_pend_d;
      first_q    <= first_d;
      err_q      <= err_d;
      rdy_q      <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    len_d      = len_q;
    pad_pend_d = pad_pend_q;
    first_d    = first_q;
    err_d      = err_q;
    buf_clr    = 1'b0;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          len_d = len_q + (LEN_W'(bv_eff) << 3);
          if ((byte_valid > BV_W'(IN_BYTES)) ||
              (!msg_last && (byte_valid != '0) && (byte_valid < BV_W'(IN_BYTES))))
            err_d = 1'b1;
          // A misaligned short beat can push fill past 64; the excess is dropped.
          fill_d = (new_fill >= 8'(BLK_BYTES)) ? 7'(BLK_BYTES) : new_fill[6:0];
          if (new_fill >= 8'(BLK_BYTES)) begin
            state_d    = FULL;
            pad_pend_d = msg_last;
          end else if (msg_last) begin
            state_d = PAD1;
          end
        end
      end
      FULL: begin
        if (xfer) begin
          first_d = 1'b0;
          fill_d  = '0;
          if (pad_pend_q) begin
            state_d = PAD1;
          end else begin
            state_d = ACCUM;
            buf_clr = 1'b1;
          end
        end
      end
      PAD1: begin
        if (xfer) begin
          first_d = 1'b0;
          if (fill_q < 7'(LEN_OFFSET)) begin
            state_d = ACCUM;
            fill_d  = '0;
            len_d   = '0;
            first_d = 1'b1;
            buf_clr = 1'b1;
          end else begin
            state_d = PAD2;
          end
        end
      end
      PAD2: begin
        if (xfer) begin
          state_d = ACCUM;
          fill_d  = '0;
          len_d   = '0;
          first_d = 1'b1;
          buf_clr = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Block contents are a pure function of registered state, so they hold
  // steady for as long as the core stalls.
  always_comb begin
    blk_valid = (state_q != ACCUM);
    blk_last  = 1'b0;
    blk_out   = '0;
    case (state_q)
      FULL: blk_out = buf_data;
      PAD1: begin
        blk_out = (buf_data & ~({BLK_BITS{1'b1}} >> {fill_q, 3'b000})) |
                  ({PAD_BYTE, {(BLK_BITS-8){1'b0}}} >> {fill_q, 3'b000});
        if (fill_q < 7'(LEN_OFFSET)) begin
          blk_last                        = 1'b1;
          blk_out[LEN_FIELD_BYTES*8-1:0] = len64;
        end
      end
      PAD2: begin
        blk_last                        = 1'b1;
        blk_out[LEN_FIELD_BYTES*8-1:0] = len64;
      end
      default: ;
    endcase
    blk_first = blk_valid && first_q;
  end

`ifdef SHA256_PADDER_STATS_EN
  logic [15:0] blk_idx_q;
  logic [31:0] msg_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_idx_q <= '0;
      msg_cnt_q <= '0;
    end else if (xfer) begin
      if (blk_last) begin
        blk_idx_q <= '0;
        msg_cnt_q <= msg_cnt_q + 32'd1;
      end else begin
        blk_idx_q <= blk_idx_q + 16'd1;
      end
    end
  end

  assign blk_idx = blk_idx_q;
  assign msg_cnt = msg_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - self-checking bench for sha256_msg_padder against a byte-queue padding model
module tb_sha256_msg_padder;

  localparam int IN_BYTES = 4;
  localparam int BV_W     = $clog2(IN_BYTES + 1);

  logic                  clk;
  logic                  rst_n;
  logic [IN_BYTES*8-1:0] data_in;
  logic [BV_W-1:0]       byte_valid;
  logic                  data_valid;
  logic                  msg_last;
  logic                  data_ready;
  logic [511:0]          blk_out;
  logic                  blk_valid;
  logic                  blk_ready;
  logic                  blk_first;
  logic                  blk_last;
  logic                  proto_err;
`ifdef SHA256_PADDER_STATS_EN
  logic [15:0]           blk_idx;
  logic [31:0]           msg_cnt;
`endif

  sha256_msg_padder #(.IN_BYTES(IN_BYTES), .LEN_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .byte_valid (byte_valid),
    .data_valid (data_valid),
    .msg_last   (msg_last),
    .data_ready (data_ready),
    .blk_out    (blk_out),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_first  (blk_first),
    .blk_last   (blk_last),
    .proto_err  (proto_err)
`ifdef SHA256_PADDER_STATS_EN
    ,
    .blk_idx    (blk_idx),
    .msg_cnt    (msg_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   cur_msg[$];
  logic [511:0] obs_blk[$];
  logic [511:0] exp_blk[$];
  bit           obs_first[$], obs_last[$], exp_first[$], exp_last[$];
  bit           rdy_rand  = 1'b0;
  bit           rdy_force = 1'b1;

  // Core-side ready: either random backpressure or a level chosen by the test.
  initial begin
    blk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      blk_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Inputs only change just after rising edges, so a handshake seen at the
  // falling edge is exactly the one that completes on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && blk_valid && blk_ready) begin
        obs_blk.push_back(blk_out);
        obs_first.push_back(blk_first);
        obs_last.push_back(blk_last);
      end
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [IN_BYTES*8-1:0] d, input int bv, input bit last);
    int cyc;
    @(posedge clk);
    #1;
    data_in    = d;
    byte_valid = BV_W'(bv);
    msg_last   = last;
    data_valid = 1'b1;
    cyc        = 0;
    @(negedge clk);
    while (!data_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("beat_accept", 512'(data_ready), 512'(1));
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    msg_last   = 1'b0;
  endtask

  task automatic send_cur(input bit with_last);
    int n;
    int pos;
    int nb;
    logic [IN_BYTES*8-1:0] d;
    n   = cur_msg.size();
    pos = 0;
    do begin
      nb = (n - pos > IN_BYTES) ? IN_BYTES : n - pos;
      for (int j = 0; j < IN_BYTES; j++)
        d[8*(IN_BYTES-1-j) +: 8] = (j < nb) ? cur_msg[pos+j] : 8'($urandom);
      send_beat(d, nb, with_last && (pos + nb == n));
      pos += nb;
    end while (pos < n);
  endtask

  // Padding rule stated on the byte sequence: message, 0x80, zeros until the
  // length is 56 mod 64, then the 64-bit big-endian bit count.
  task automatic build_expected();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] b;
    int           nblk;
    p = cur_msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(cur_msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nblk = p.size() / 64;
    for (int bi = 0; bi < nblk; bi++) begin
      b = '0;
      for (int j = 0; j < 64; j++) b[8*(63-j) +: 8] = p[64*bi + j];
      exp_blk.push_back(b);
      exp_first.push_back(bi == 0);
      exp_last.push_back(bi == nblk - 1);
    end
  endtask

  task automatic check_msg(input string tag);
    int cyc;
    cyc = 0;
    while (obs_blk.size() < exp_blk.size() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_count"}, 512'(obs_blk.size()), 512'(exp_blk.size()));
    while (exp_blk.size() > 0 && obs_blk.size() > 0) begin
      chk({tag, "_data"},  obs_blk.pop_front(),        exp_blk.pop_front());
      chk({tag, "_first"}, 512'(obs_first.pop_front()), 512'(exp_first.pop_front()));
      chk({tag, "_last"},  512'(obs_last.pop_front()),  512'(exp_last.pop_front()));
    end
    obs_blk.delete(); obs_first.delete(); obs_last.delete();
    exp_blk.delete(); exp_first.delete(); exp_last.delete();
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_ready"}, 512'(data_ready), 512'(0));
    chk({tag, "_blk_valid"},  512'(blk_valid),  512'(0));
    chk({tag, "_blk_out"},    blk_out,          512'(0));
    chk({tag, "_blk_first"},  512'(blk_first),  512'(0));
    chk({tag, "_blk_last"},   512'(blk_last),   512'(0));
    chk({tag, "_proto_err"},  512'(proto_err),  512'(0));
  endtask

  logic [511:0] abc_blk;
  logic [511:0] hold;

  initial begin
    rst_n      = 1'b0;
    data_in    = '0;
    byte_valid = '0;
    data_valid = 1'b0;
    msg_last   = 1'b0;
    abc_blk    = {32'h61626380, 416'd0, 64'h18};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_clk", 512'(data_ready), 512'(0));
    @(posedge clk);
    #1;
    chk("ready_after_clk", 512'(data_ready), 512'(1));

    // "abc": single block, valid the cycle after the last beat is taken
    cur_msg = '{8'h61, 8'h62, 8'h63};
    build_expected();
    send_cur(1'b1);
    chk("abc_latency", 512'(blk_valid), 512'(1));
    chk("abc_const",   blk_out,         abc_blk);
    chk("abc_first",   512'(blk_first), 512'(1));
    chk("abc_last",    512'(blk_last),  512'(1));
    check_msg("abc");

    cur_msg.delete();
    build_expected();
    send_cur(1'b1);
    check_msg("empty");

    cur_msg.delete();
    for (int i = 0; i < 55; i++) cur_msg.push_back(8'h00);
    build_expected();
    send_cur(1'b1);
    check_msg("len55");

    cur_msg.delete();
    for (int i = 0; i < 56; i++) cur_msg.push_back(8'(i));
    build_expected();
    send_cur(1'b1);
    check_msg("len56");

    cur_msg.delete();
    for (int i = 0; i < 64; i++) cur_msg.push_back(8'hAA);
    build_expected();
    send_cur(1'b1);
    check_msg("len64");

    rdy_rand = 1'b1;
    for (int t = 0; t < 12; t++) begin
      cur_msg.delete();
      for (int i = 0; i < int'($urandom_range(0, 200)); i++) cur_msg.push_back(8'($urandom));
      build_expected();
      send_cur(1'b1);
      check_msg("random");
    end
    rdy_rand  = 1'b0;
    rdy_force = 1'b1;
    chk("no_proto_err", 512'(proto_err), 512'(0));

    // Stall a full data block and confirm it is held
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cur_msg.delete();
    for (int i = 0; i < 64; i++) cur_msg.push_back(8'h5C);
    send_cur(1'b0);
    hold = blk_out;
    chk("stall_valid", 512'(blk_valid), 512'(1));
    chk("stall_data",  hold,            {64{8'h5C}});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_stable", blk_out,          hold);
      chk("stall_ready",  512'(data_ready), 512'(0));
      chk("stall_vld",    512'(blk_valid),  512'(1));
    end

    // Reset while the stalled block is pending: it must vanish
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    chk("midrst_no_blocks", 512'(obs_blk.size()), 512'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    rdy_force = 1'b1;
    @(posedge clk);
    #1;
    cur_msg = '{8'h61, 8'h62, 8'h63};
    build_expected();
    send_cur(1'b1);
    chk("abc2_const", blk_out, abc_blk);
    check_msg("abc_after_rst");

    // Oversized byte_valid is clamped and flagged
    reset_pulse();
    send_beat(32'h01020304, 7, 1'b1);
    cur_msg = '{8'h01, 8'h02, 8'h03, 8'h04};
    build_expected();
    check_msg("clamp");
    chk("clamp_err", 512'(proto_err), 512'(1));

    // Short non-final beat is written but flagged
    reset_pulse();
    chk("short_err_clear", 512'(proto_err), 512'(0));
    send_beat(32'h1122EEFF, 2, 1'b0);
    send_beat(32'h33445566, 4, 1'b1);
    cur_msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    build_expected();
    check_msg("short");
    chk("short_err", 512'(proto_err), 512'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
